// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and encodings for the serial add/sub unit
//
// Purpose: mode and FSM state encodings used by serial_addsub and its bench.
// Ports: none (package).
package addsub_pkg;

  // Operation mode encodings as presented on the mode input.
  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_CMP  = 2'b10;
  localparam logic [1:0] MODE_RSUB = 2'b11;

  // FSM state encodings; the state register is a plain logic [1:0].
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ADD  = MODE_ADD,
    SUB  = MODE_SUB,
    CMP  = MODE_CMP,
    RSUB = MODE_RSUB
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    BUSY = S_BUSY,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple-carry slice
//
// Purpose: adds one DIGIT-bit slice of the prepared operands plus a carry.
// Ports:
//   x, y   in  DIGIT  operand slices
//   ci     in  1      carry into bit 0
//   sum    out DIGIT  slice sum
//   co     out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (for signed overflow)
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial add/subtract/compare unit with handshakes
//
// Purpose: computes add/sub/cmp/rsub one DIGIT-bit slice per clock, LSB first,
// reusing a single digit_adder; latency WIDTH/DIGIT cycles from accept.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only when idle)
//   a, b, mode, cin       operands, operation select, carry/borrow-in
//   out_valid / out_ready result handshake
//   result                sum/difference (zero in cmp mode)
//   cout, zero, leq, ovf  carry/not-borrow, zero, less-or-equal, signed overflow
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             leq,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]       state_q;
  mode_t            mode_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] acc_q;
  logic             carry_q;
  logic             zacc_q;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0] sum;
  logic             co;
  logic             c_msb;
  logic             last;
  logic [WIDTH-1:0] sum_ext;
  logic [WIDTH-1:0] acc_next;
  logic             zero_next;

  digit_adder #(.DIGIT(DIGIT)) u_slice (
    .x     (x_q[DIGIT-1:0]),
    .y     (y_q[DIGIT-1:0]),
    .ci    (carry_q),
    .sum   (sum),
    .co    (co),
    .c_msb (c_msb)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign last      = (cnt_q == CW'(N - 1));

  // Result assembles MSB-side: each new slice enters at the top and the
  // register shifts right, so after N slices slice 0 sits at bit 0.
  assign sum_ext   = WIDTH'(sum);
  assign acc_next  = (acc_q >> DIGIT) | (sum_ext << (WIDTH - DIGIT));
  assign zero_next = zacc_q & (sum == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= ADD;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      cnt_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
      leq     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mode_q <= mode_t'(mode);
            cnt_q  <= '0;
            zacc_q <= 1'b1;
            acc_q  <= '0;
            // Subtraction is X + ~Y + c0; cmp always uses a clean borrow-in.
            case (mode)
              MODE_ADD: begin
                x_q <= a; y_q <= b; carry_q <= cin;
              end
              MODE_SUB: begin
                x_q <= a; y_q <= ~b; carry_q <= ~cin;
              end
              MODE_CMP: begin
                x_q <= a; y_q <= ~b; carry_q <= 1'b1;
              end
              default: begin
                x_q <= b; y_q <= ~a; carry_q <= ~cin;
              end
            endcase
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          x_q     <= x_q >> DIGIT;
          y_q     <= y_q >> DIGIT;
          carry_q <= co;
          acc_q   <= acc_next;
          zacc_q  <= zero_next;
          cnt_q   <= cnt_q + CW'(1);
          if (last) begin
            // Flags are published only here so they stay frozen through DONE.
            result  <= (mode_q == CMP) ? '0 : acc_next;
            cout    <= co;
            zero    <= zero_next;
            ovf     <= c_msb ^ co;
            leq     <= (mode_q != ADD) & (~co | zero_next);
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (WIDTH=16, DIGIT=4)
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  mode;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        zero;
  logic        leq;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .leq       (leq),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        co;
    logic        z;
    logic        l;
    logic        o;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  m;
    logic        c;
    exp_t        e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic: the true difference/sum,
  // its range as a signed value, and its sign decide every flag.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_v,
                                 input logic [1:0] m, input logic c);
    int   ua, ub, sa, sb, ut, st, ci;
    exp_t e;
    logic [15:0] internal;
    ua = int'(ta);
    ub = int'(tb_v);
    sa = int'($signed(ta));
    sb = int'($signed(tb_v));
    ci = (m == 2'b10) ? 0 : int'(c);
    case (m)
      2'b00:   begin ut = ua + ub + ci; st = sa + sb + ci; end
      2'b11:   begin ut = ub - ua - ci; st = sb - sa - ci; end
      default: begin ut = ua - ub - ci; st = sa - sb - ci; end
    endcase
    internal = ut[15:0];
    e.co  = (m == 2'b00) ? (ut > 65535) : (ut >= 0);
    e.o   = (st > 32767) || (st < -32768);
    e.z   = (internal == 16'h0000);
    e.l   = (m == 2'b00) ? 1'b0 : ((ut < 0) || (internal == 16'h0000));
    e.res = (m == 2'b10) ? 16'h0000 : internal;
    return e;
  endfunction

  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic [1:0] tm,
                        input logic tc, input int hold, output exp_t got, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    a = ta; b = tb_v; mode = tm; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    got = {result, cout, zero, leq, ovf};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 0);
  endtask

  task automatic cmp_exp(input string tag, input exp_t got, input exp_t e);
    chk({tag, "_result"}, got.res, e.res);
    chk({tag, "_cout"},   got.co,  e.co);
    chk({tag, "_zero"},   got.z,   e.z);
    chk({tag, "_leq"},    got.l,   e.l);
    chk({tag, "_ovf"},    got.o,   e.o);
  endtask

  vec_t        tbl[8];
  exp_t        got;
  exp_t        snap;
  int          lat;
  logic [15:0] ra, rb;
  logic [1:0]  rm;
  logic        rc;
  logic [15:0] corner[4];

  initial begin
    // {a, b, mode, cin, {result, cout, zero, leq, ovf}}
    tbl[0] = '{16'hFFFF, 16'h0001, 2'b00, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[1] = '{16'h1234, 16'h1234, 2'b01, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1, 1'b0}};
    tbl[2] = '{16'h8000, 16'h0001, 2'b01, 1'b0, '{16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    tbl[3] = '{16'h0005, 16'h0007, 2'b10, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[4] = '{16'h0003, 16'h000A, 2'b11, 1'b0, '{16'h0007, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[5] = '{16'h7FFF, 16'h0001, 2'b00, 1'b0, '{16'h8000, 1'b0, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{16'h000A, 16'h0003, 2'b11, 1'b0, '{16'hFFF9, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[7] = '{16'h0010, 16'h0005, 2'b01, 1'b1, '{16'h000A, 1'b1, 1'b0, 1'b0, 1'b0}};
    corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000; corner[3] = 16'h7FFF;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; mode = 2'b00; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, zero, leq, ovf}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].c, i % 3, got, lat);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      cmp_exp($sformatf("vec%0d", i), got, tbl[i].e);
    end

    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      rm = 2'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rm, rc, $urandom_range(0, 3), got, lat);
      chk($sformatf("rnd%0d_latency", i), lat, 4);
      cmp_exp($sformatf("rnd%0d", i), got, model(ra, rb, rm, rc));
    end

    // Back-pressure: DONE held 10 cycles, a stray in_valid must be ignored.
    a = 16'h1111; b = 16'h2222; mode = 2'b00; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_latency", lat, 4);
    snap = {result, cout, zero, leq, ovf};
    cmp_exp("bp", snap, '{16'h3333, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        a = 16'h0F0F; b = 16'h0101; mode = 2'b01; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_outputs", i), {result, cout, zero, leq, ovf}, 32'(snap));
      chk($sformatf("bp_hold%0d_valid_ready", i), {out_valid, in_ready}, 2'b10);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_stray_not_started", out_valid, 0);

    // Reset during slice 2 of an operation.
    a = 16'h8000; b = 16'h0001; mode = 2'b01; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_flags", {cout, zero, leq, ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0101, 2'b00, 1'b1, 0, got, lat);
    chk("postrst_latency", lat, 4);
    cmp_exp("postrst", got, '{16'h0201, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
